// File: rtl/instr_asm_pkg.sv
// Shared types and lane-placement helper for the instruction assembler.
package instr_asm_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  typedef enum logic {
    LITTLE = 1'b0,
    BIG    = 1'b1
  } order_t;

  // Bit position of the LSB of lane k inside a word of 'bytes' lanes.
  function automatic int lane_lsb(input int k, input int bytes, input int data_w,
                                  input order_t order);
    if (order == BIG) begin
      return (bytes - 1 - k) * data_w;
    end else begin
      return k * data_w;
    end
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Collects consecutive bytes into lanes of one word. The word output already
// includes a byte being captured this cycle, so the final byte can be
// forwarded without waiting for it to be registered.
module byte_packer
  import instr_asm_pkg::*;
#(
  parameter int     DATA_W = 8,
  parameter int     BYTES  = 4,
  parameter order_t ORDER  = BIG,
  localparam int    WORD_W = DATA_W * BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic [DATA_W-1:0] data,
  input  logic              clear,
  output logic [WORD_W-1:0] word,
  output logic              complete
);

  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [IDX_W-1:0] idx_reg;
  logic             complete_reg;
  logic             last_capture;

  assign last_capture = capture && (idx_reg == IDX_W'(BYTES - 1));
  assign complete     = complete_reg || last_capture;

  // Capture index and complete flag; clear restarts an empty word.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx_reg      <= '0;
      complete_reg <= 1'b0;
    end else if (capture) begin
      idx_reg <= last_capture ? '0 : idx_reg + 1'b1;
      if (last_capture) begin
        complete_reg <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
    localparam int LSB = lane_lsb(gi, BYTES, DATA_W, ORDER);

    logic [DATA_W-1:0] lane_reg;
    logic              hit;

    assign hit = capture && (idx_reg == IDX_W'(gi));

    // Lane register: loads the byte whose index within the word is gi.
    always_ff @(posedge clk) begin
      if (rst || clear) begin
        lane_reg <= '0;
      end else if (hit) begin
        lane_reg <= data;
      end
    end

    assign word[LSB +: DATA_W] = hit ? data : lane_reg;
  end

endmodule

// File: rtl/instruction_assembler.sv
// Fetches bytes from a 1-cycle-latency byte memory and packs BYTES of them
// into instruction words presented on a valid/ready output.
module instruction_assembler
  import instr_asm_pkg::*;
#(
  parameter int          DATA_W     = 8,
  parameter int          BYTES      = 4,
  parameter int          ADDR_W     = 8,
  parameter bit          BIG_ENDIAN = 1'b1,
  parameter int unsigned START_ADDR = 0,
  localparam int         WORD_W     = DATA_W * BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [WORD_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              busy
);

  localparam order_t ORDER = BIG_ENDIAN ? BIG : LITTLE;

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] pc_reg;
  logic              inflight_reg;
  logic [ADDR_W-1:0] last_addr_reg;
  logic              instr_valid_reg;
  logic [WORD_W-1:0] instr_out_reg;
  logic [ADDR_W-1:0] instr_addr_reg;

  logic [WORD_W-1:0] packed_word;
  logic              word_complete;
  logic              transfer_ok;
  logic              stall;
  logic              transfer;

  // A finished word may only leave when the output slot is free or being
  // accepted; otherwise reads stop so nothing overwrites the finished word.
  assign transfer_ok = !instr_valid_reg || instr_ready;
  assign stall       = word_complete && !transfer_ok;
  assign transfer    = word_complete && transfer_ok && !load_en;

  byte_packer #(
    .DATA_W(DATA_W),
    .BYTES (BYTES),
    .ORDER (ORDER)
  ) u_packer (
    .clk     (clk),
    .rst     (rst),
    .capture (inflight_reg),
    .data    (mem_data),
    .clear   (load_en || transfer),
    .word    (packed_word),
    .complete(word_complete)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: start launches fetching; fetching runs until reset.
  always_comb begin
    state_next = state_reg;
    if (state_reg == IDLE && start) begin
      state_next = FETCH;
    end
  end

  // Outputs decoded from state and stall.
  always_comb begin
    busy   = (state_reg == FETCH);
    mem_rd = (state_reg == FETCH) && !stall;
  end

  // Program counter: jump on load, otherwise advance per issued read.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= ADDR_W'(START_ADDR);
    end else if (load_en) begin
      pc_reg <= load_addr;
    end else if (mem_rd) begin
      pc_reg <= pc_reg + 1'b1;
    end
  end

  // Read tracking: a jump discards whatever read is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_reg  <= 1'b0;
      last_addr_reg <= '0;
    end else begin
      inflight_reg <= mem_rd && !load_en;
      if (mem_rd) begin
        last_addr_reg <= pc_reg;
      end
    end
  end

  // Output register; while transferring, last_addr_reg holds the address of
  // the word's final byte, so the start address is BYTES-1 below it.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_valid_reg <= 1'b0;
      instr_out_reg   <= '0;
      instr_addr_reg  <= '0;
    end else if (load_en) begin
      instr_valid_reg <= 1'b0;
    end else if (transfer) begin
      instr_valid_reg <= 1'b1;
      instr_out_reg   <= packed_word;
      instr_addr_reg  <= last_addr_reg - ADDR_W'(BYTES - 1);
    end else if (instr_ready) begin
      instr_valid_reg <= 1'b0;
    end
  end

  assign mem_addr    = pc_reg;
  assign instr_valid = instr_valid_reg;
  assign instr_out   = instr_out_reg;
  assign instr_addr  = instr_addr_reg;

endmodule
